// File: rtl/regfile_pkg.sv
// Shared defaults, register-index type and write-port priority helper for the multi-port regfile.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int MAX_WR    = 32;

    typedef logic [AW_DEF-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_IDX = '0;

    // Index of the highest set bit; the caller guarantees at least one bit is set.
    function automatic int hi_hit(input logic [MAX_WR-1:0] hits);
        int idx;
        idx = 0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (hits[j]) idx = j;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue reservations, cleared by writebacks.
// Combinational rsv_ready; a same-cycle write to a pending register frees it for a new reservation.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rsv_ready,
    output logic [NREGS-1:0]  wr_hit,
    output logic [NREGS-1:0]  pending
);

    logic [NREGS-1:0] set_mask;

    always_comb begin
        wr_hit   = '0;
        set_mask = '0;
        for (int j = 0; j < NWR; j++) begin
            if (we[j]) wr_hit[waddr[j*AW +: AW]] = 1'b1;
        end
        rsv_ready = !pending[rsv_addr] || wr_hit[rsv_addr];
        // Register 0 accepts reservations but never records them.
        if (rsv_valid && rsv_ready && !(ZERO_REG != 0 && rsv_addr == AW'(ZERO_IDX)))
            set_mask[rsv_addr] = 1'b1;
    end

    // Set is applied after clear so a reservation racing its own writeback stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~wr_hit) | set_mask;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-priority, same-cycle bypass and a pending-write scoreboard.
// Reads are zero-latency; writes land on posedge; issue stalls while rsv_ready is low.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rpend,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    output logic [NREGS-1:0]    pending
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] wr_hit;

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .wr_hit    (wr_hit),
        .pending   (pending)
    );

    function automatic logic [MAX_WR-1:0] hits_for(input logic [AW-1:0] a);
        logic [MAX_WR-1:0] h;
        h = '0;
        for (int j = 0; j < NWR; j++) begin
            h[j] = we[j] && (waddr[j*AW +: AW] == a);
        end
        return h;
    endfunction

    // Ports are visited in ascending order so the highest-index write is the last NBA and wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && !(ZERO_REG != 0 && waddr[j*AW +: AW] == AW'(ZERO_IDX)))
                    mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
            end
        end
    end

    // Gating on rst_n keeps bypassed write data off the read ports while reset is held.
    always_comb begin
        rdata = '0;
        rpend = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!rst_n || (ZERO_REG != 0 && raddr[k*AW +: AW] == AW'(ZERO_IDX))) begin
                rdata[k*XLEN +: XLEN] = '0;
            end else if (BYPASS != 0 && wr_hit[raddr[k*AW +: AW]]) begin
                rdata[k*XLEN +: XLEN] = wdata[hi_hit(hits_for(raddr[k*AW +: AW]))*XLEN +: XLEN];
            end else begin
                rdata[k*XLEN +: XLEN] = mem[raddr[k*AW +: AW]];
                rpend[k]              = pending[raddr[k*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: bypass and non-bypass instances share stimulus and are checked every cycle
// against an array/bitmap reference model, with directed literal checks from the test plan.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  raddr;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;

    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rpend_b, rpend_n;
    logic        rsv_ready_b, rsv_ready_n;
    logic [31:0] pending_b, pending_n;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_mem [32];
    logic [31:0] m_pend;

    always #5 clk = ~clk;

    regfile_mp_sb #(.BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rpend(rpend_b),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rsv_ready(rsv_ready_b), .pending(pending_b)
    );

    regfile_mp_sb #(.BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rpend(rpend_n),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rsv_ready(rsv_ready_n), .pending(pending_n)
    );

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic rv, input logic [4:0] ra);
        we        = w;
        waddr     = {wa1, wa0};
        wdata     = {wd1, wd0};
        raddr     = {ra1, ra0};
        rsv_valid = rv;
        rsv_addr  = ra;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, ra0, ra1, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what a read port must show given stored state and this cycle's writes.
    function automatic logic [31:0] m_rd(input int k, input bit byp);
        logic [4:0]  a;
        logic [31:0] d;
        bit          hit;
        a   = raddr[k*5 +: 5];
        hit = 1'b0;
        d   = 32'h0;
        for (int j = 0; j < 2; j++) begin
            if (we[j] && waddr[j*5 +: 5] == a) begin
                hit = 1'b1;
                d   = wdata[j*32 +: 32];
            end
        end
        if (a == 5'd0)   return 32'h0;
        if (byp && hit)  return d;
        return m_mem[a];
    endfunction

    function automatic logic m_rp(input int k, input bit byp);
        logic [4:0] a;
        bit         hit;
        a   = raddr[k*5 +: 5];
        hit = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (we[j] && waddr[j*5 +: 5] == a) hit = 1'b1;
        end
        if (a == 5'd0 || (byp && hit)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic m_ready();
        bit clr;
        clr = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (we[j] && waddr[j*5 +: 5] == rsv_addr) clr = 1'b1;
        end
        return !m_pend[rsv_addr] || clr;
    endfunction

    // Per-cycle compare, then advance the model by the effect of the coming posedge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic rdy;
            if (!rst_n) begin
                m_pend = 32'h0;
                for (int r = 0; r < 32; r++) m_mem[r] = 32'h0;
            end
            for (int k = 0; k < 2; k++) begin
                chk32($sformatf("rdata%0d_byp", k), rdata_b[k*32 +: 32], rst_n ? m_rd(k, 1'b1) : 32'h0);
                chk32($sformatf("rdata%0d_nobyp", k), rdata_n[k*32 +: 32], rst_n ? m_rd(k, 1'b0) : 32'h0);
                chk1($sformatf("rpend%0d_byp", k), rpend_b[k], rst_n ? m_rp(k, 1'b1) : 1'b0);
                chk1($sformatf("rpend%0d_nobyp", k), rpend_n[k], rst_n ? m_rp(k, 1'b0) : 1'b0);
            end
            rdy = rst_n ? m_ready() : 1'b1;
            chk1("rsv_ready_byp", rsv_ready_b, rdy);
            chk1("rsv_ready_nobyp", rsv_ready_n, rdy);
            chk32("pending_byp", pending_b, m_pend);
            chk32("pending_nobyp", pending_n, m_pend);
            if (rst_n) begin
                for (int j = 0; j < 2; j++) begin
                    if (we[j] && waddr[j*5 +: 5] != 5'd0) begin
                        m_mem[waddr[j*5 +: 5]]  = wdata[j*32 +: 32];
                        m_pend[waddr[j*5 +: 5]] = 1'b0;
                    end
                end
                if (rsv_valid && rdy && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle(5'd5, 5'd0);
        m_pend = 32'h0;
        for (int r = 0; r < 32; r++) m_mem[r] = 32'h0;
        #2;
        chk32("reset_rdata", rdata_b[31:0], 32'h0);
        chk32("reset_pending", pending_b, 32'h0);
        chk1("reset_rsv_ready", rsv_ready_b, 1'b1);
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // x5 written, then async reset mid-cycle.
        drive(2'b01, 5'd5, 32'hA5A5A5A5, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
        tick();
        idle(5'd5, 5'd0);
        #1;
        chk32("x5_written", rdata_b[31:0], 32'hA5A5A5A5);
        #1;
        rst_n = 1'b0;
        #1;
        chk32("async_reset_rdata", rdata_b[31:0], 32'h0);
        chk32("async_reset_pending", pending_b, 32'h0);
        tick();
        rst_n = 1'b1;

        // x3 write and a dropped write to x0.
        drive(2'b11, 5'd3, 32'hDEADBEEF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0);
        tick();
        idle(5'd3, 5'd0);
        #1;
        chk32("x3_read", rdata_b[31:0], 32'hDEADBEEF);
        chk32("x0_read", rdata_b[63:32], 32'h0);

        // Write priority and bypass on x10.
        tick();
        drive(2'b11, 5'd10, 32'h11111111, 5'd10, 32'h12345678, 5'd10, 5'd0, 1'b0, 5'd0);
        #1;
        chk32("bypass_same_cycle", rdata_b[31:0], 32'h12345678);
        chk32("nobypass_same_cycle", rdata_n[31:0], 32'h0);
        tick();
        idle(5'd10, 5'd0);
        #1;
        chk32("prio_stored_byp", rdata_b[31:0], 32'h12345678);
        chk32("prio_stored_nobyp", rdata_n[31:0], 32'h12345678);

        // Reserve x7, re-reserve, writeback.
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7);
        #1;
        chk1("rsv7_ready", rsv_ready_b, 1'b1);
        chk1("rsv7_rpend_same_cycle", rpend_b[0], 1'b0);
        tick();
        #1;
        chk1("rsv7_again_stall", rsv_ready_b, 1'b0);
        chk1("rsv7_pending", pending_b[7], 1'b1);
        chk1("rsv7_rpend", rpend_b[0], 1'b1);
        tick();
        drive(2'b01, 5'd7, 32'hCAFEF00D, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0);
        #1;
        chk1("wb7_rpend_bypass", rpend_b[0], 1'b0);
        chk1("wb7_rpend_nobypass", rpend_n[0], 1'b1);
        tick();
        idle(5'd7, 5'd0);
        #1;
        chk1("wb7_pending_cleared", pending_b[7], 1'b0);
        chk32("wb7_data", rdata_b[31:0], 32'hCAFEF00D);

        // Reservation racing its own writeback.
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7);
        tick();
        drive(2'b01, 5'd7, 32'h1, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7);
        #1;
        chk1("race_rsv_ready", rsv_ready_b, 1'b1);
        tick();
        idle(5'd7, 5'd0);
        #1;
        chk1("race_pending_kept", pending_b[7], 1'b1);
        chk32("race_data", rdata_b[31:0], 32'h1);

        // Reset discards outstanding reservations.
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4);
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9);
        tick();
        idle(5'd0, 5'd0);
        #1;
        chk32("pending_before_reset", pending_b, 32'h00000290);
        #1;
        rst_n = 1'b0;
        #1;
        chk32("pending_after_reset", pending_b, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd4);
        #1;
        chk1("rsv4_ready_after_reset", rsv_ready_b, 1'b1);
        for (int i = 0; i < 32; i++) begin
            tick();
            idle(5'(i), 5'(31 - i));
            #1;
            chk32($sformatf("cleared_x%0d", i), rdata_b[31:0], 32'h0);
        end

        // Randomized traffic with narrow address ranges to force collisions.
        for (int c = 0; c < 3000; c++) begin
            tick();
            drive(2'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  1'($urandom), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end

        tick();
        idle(5'd0, 5'd0);
        tick();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with an integrated pending-write scoreboard.
- Successor to the single-write, dual-read regfile.
- Adds asynchronous reset, N read ports, M prioritised write ports, same-cycle write-to-read bypass, and per-register reservation tracking.
- Sits between the RV decode/issue stage and the writeback paths (ALU and ML coprocessor). Issue reserves rd; the long-latency coprocessor clears the reservation on writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2). AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports. Higher index has higher priority.
- BYPASS, 1. 1 = same-cycle write data and reservation clear are visible on the read ports. 0 = reads show only registered state.
- ZERO_REG, 1. 1 = register 0 reads as 0, ignores writes, and is never pending.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  NRD*AW  read addresses, port k at [k*AW +: AW].
- rdata  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN].
- rpend  out  NRD  port k addresses a register with an outstanding reservation.
- we  in  NWR  write enables.
- waddr  in  NWR*AW  write addresses.
- wdata  in  NWR*XLEN  write data.
- rsv_valid  in  1  request to reserve register rsv_addr.
- rsv_addr  in  AW  register to reserve.
- rsv_ready  out  1  reservation is accepted this cycle.
- pending  out  NREGS  registered pending bitmap.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers clear to 0.
  - pending clears to 0.
  - Outputs during reset: rdata=0, rpend=0, rsv_ready=1.
- Write, on posedge for each port j with we[j]=1:
  - mem[waddr_j] <= wdata_j.
  - pending[waddr_j] clears.
  - If several ports target the same address, the highest j wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational, zero latency):
  - rdata_k = mem[raddr_k].
  - With BYPASS=1 and any we[j] with waddr_j==raddr_k in the same cycle, rdata_k = wdata of the highest such j.
  - With ZERO_REG=1, raddr_k==0 gives rdata_k=0 and is never bypassed.
- rpend_k:
  - rpend_k = pending[raddr_k].
  - With BYPASS=1, rpend_k is forced to 0 when a same-cycle write targets raddr_k.
  - A same-cycle reservation does not raise rpend (visible next cycle).
- Reservation:
  - rsv_ready = !pending[rsv_addr] OR (a same-cycle write clears rsv_addr).
  - Accept = rsv_valid & rsv_ready. On accept, pending[rsv_addr] <= 1 at posedge.
  - Simultaneous accept and write to the same register: the write updates data and the new reservation wins, so pending stays 1.
  - With ZERO_REG=1, reserving address 0 is always accepted and has no effect.
  - A reservation of an already-pending register with no clearing write: rsv_ready=0, state unchanged. Issue must stall.
- A write to a register that is not pending is legal: data updates, pending stays 0.
- Reset mid-operation: all pending reservations are discarded. Writebacks in flight after reset are handled as normal writes.
- Out-of-range addresses are not possible, because NREGS is a power of two.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEF, NREGS_DEF.
  - Register-index typedef (logic [AW-1:0]).
  - ZERO_IDX constant.
  - Helper function for highest-priority write-hit select.
- Sub-module regfile_scoreboard:
  - Owns the pending bitmap, the rsv_ready logic and the clear/set priority.
  - Data array, bypass mux and read ports stay in the top module.

Test Plan:
- Reset then read: assert rst_n=0 mid-cycle after writing x5=0xA5A5A5A5. Required: rdata on raddr=5 is 0 immediately (async), and pending=0.
- Write/read and x0: we[0]=1, waddr=3, wdata=0xDEADBEEF. Next cycle raddr0=3 gives 0xDEADBEEF. A write of 0xFFFFFFFF to x0 leaves raddr1=0 reading 0.
- Write priority and bypass:
  - Same cycle: we=2'b11 with both ports at x10, wdata0=0x11111111, wdata1=0x12345678, and raddr0=10.
  - Required: 0x12345678 in the same cycle (BYPASS=1), and 0x12345678 stored.
  - With BYPASS=0: the old value in the same cycle, 0x12345678 next cycle.
- Scoreboard set/clear:
  - Reserve x7: rsv_ready=1, then pending[7]=1 and rpend=1 on raddr=7.
  - A second reserve of x7 gives rsv_ready=0.
  - Writeback we=1, waddr=7, wdata=0xCAFEF00D gives rpend=0 in the same cycle (bypass) and pending[7]=0 next cycle.
- Simultaneous reserve and write: with x7 pending, write x7=0x1 and reserve x7 in the same cycle. Required: rsv_ready=1, mem[7]=0x1, pending[7] remains 1.
- Reset during pending: reserve x4 and x9, then pulse rst_n. Required: pending=0, rsv_ready=1 for x4, and all rdata read 0.
